// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//   Round-robin arbiter that shares one multi-cycle FP adder among N_REQ
//   requesters. Each served requester holds gnt from grant through the
//   response cycle and receives a one-cycle done pulse with the sum on result.
//
//   Ports
//     clk, rst        clock (rising edge), asynchronous active-high reset
//     req             per-requester level request, held until its done pulse
//     a_flat, b_flat  operands, requester i at bits [i*W +: W]
//     gnt             one-hot grant, grant through end of RESP
//     done            one-cycle pulse to the served requester
//     result          sum, valid while any done bit is high
//     add_start       start pulse to the shared adder (only when !add_busy)
//     add_a, add_b    adder operands, held from grant through RESP
//     add_busy        adder busy
//     add_valid       adder result-valid pulse (looked at only in WAIT)
//     add_out         adder result
//     timeout_err     sticky abort flag
//
//   Build option
//     FP_ADD_ARB_TIMEOUT_EN  bounds WAIT to TIMEOUT cycles; on expiry the
//     transaction completes with a quiet NaN result and timeout_err is set.
//     Without it WAIT is unbounded and timeout_err is tied to 0.

module fp_add_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_flat,
  input  logic [N_REQ*W-1:0] b_flat,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       result,
  output logic               add_start,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  input  logic               add_busy,
  input  logic               add_valid,
  input  logic [W-1:0]       add_out,
  output logic               timeout_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("fp_add_arbiter: N_REQ must be 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fp_add_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] g_idx;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          tmo_hit;

  // Rotating priority: scan from rr_ptr upward, wrapping at N_REQ-1.
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IW'(idx);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

`ifdef FP_ADD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  // Held at zero outside WAIT, so it is already clear on WAIT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tmo_cnt <= '0;
    else if (state != WAIT) tmo_cnt <= '0;
    else                    tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Fires in the TIMEOUT-th WAIT cycle; a late add_valid in that same cycle wins.
  assign tmo_hit = (state == WAIT) && !add_valid && (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          timeout_err <= 1'b0;
    else if (tmo_hit) timeout_err <= 1'b1;
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // add_start is combinational so a busy adder holds it low in the same cycle.
  always_comb begin
    state_nxt = state;
    add_start = 1'b0;
    case (state)
      IDLE:  if (pick_vld) state_nxt = ISSUE;
      ISSUE: if (!add_busy) begin
               add_start = 1'b1;
               state_nxt = WAIT;
             end
      WAIT:  if (add_valid || tmo_hit) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // gnt is one-hot while busy, so masking it gives a one-hot done.
  assign done = (state == RESP) ? gnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= '0;
      g_idx  <= '0;
      rr_ptr <= '0;
      add_a  <= '0;
      add_b  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          gnt   <= N_REQ'(1) << pick_idx;
          g_idx <= pick_idx;
          add_a <= a_flat[pick_idx*W +: W];
          add_b <= b_flat[pick_idx*W +: W];
        end
        WAIT: begin
          if (add_valid)    result <= add_out;
          else if (tmo_hit) result <= W'(32'h7FC0_0000);
        end
        RESP: begin
          gnt    <= '0;
          rr_ptr <= (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
